// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider: each channel emits a 50% square wave or a
// one-cycle tick, with divisor/mode updates staged and committed at the period boundary.
module clk_div_bank #(
  parameter int          N_CH     = 2,
  parameter int          CNT_W    = 32,
  parameter int unsigned DEF_DIV  = 32'd67_500_000,
  parameter bit          DEF_MODE = 1'b0,
  localparam int         CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_CH-1:0]   en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  logic [N_CH-1:0] w_pend;
  logic            w_ch_ok;
  logic            w_ready;

  assign w_ch_ok = (int'(cfg_ch) < N_CH);

  // Out-of-range channel requests are always accepted and then dropped
  always_comb begin
    w_ready = 1'b1;
    if (w_ch_ok) begin
      w_ready = !w_pend[cfg_ch];
    end else begin
      w_ready = 1'b1;
    end
  end

  assign cfg_ready = w_ready;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_mode;
    logic             r_pend;
    logic [CNT_W-1:0] r_sdiv;
    logic             r_smode;
    logic             r_clk;
    logic             r_tick;
    logic             w_halt;
    logic             w_evt;
    logic             w_commit;
    logic             w_acc;

    assign w_halt   = !en[g] || (r_div == '0);
    assign w_evt    = !w_halt && (r_cnt == (r_div - CNT_W'(1)));
    assign w_commit = r_pend && (w_evt || w_halt);
    assign w_acc    = cfg_valid && w_ready && w_ch_ok && (int'(cfg_ch) == g);

    assign w_pend[g]  = r_pend;
    assign clk_out[g] = r_clk;
    assign tick[g]    = r_tick;

    // Staging register: accept sets pending, commit clears it (never both at once)
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_pend  <= 1'b0;
        r_sdiv  <= CNT_W'(DEF_DIV);
        r_smode <= DEF_MODE;
      end else if (w_acc) begin
        r_pend  <= 1'b1;
        r_sdiv  <= cfg_div;
        r_smode <= cfg_mode;
      end else if (w_commit) begin
        r_pend  <= 1'b0;
      end else begin
        r_pend  <= r_pend;
      end
    end

    // Period counter and output flops; a commit restarts the period with outputs low
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_cnt  <= '0;
        r_div  <= CNT_W'(DEF_DIV);
        r_mode <= DEF_MODE;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_commit) begin
        r_cnt  <= '0;
        r_div  <= r_sdiv;
        r_mode <= r_smode;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_halt) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_evt) begin
        r_cnt <= '0;
        if (r_mode) begin
          r_tick <= 1'b1;
          r_clk  <= 1'b0;
        end else begin
          r_tick <= 1'b0;
          r_clk  <= !r_clk;
        end
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios then random traffic, all checked against
// an edge-count model (outputs derived arithmetically from edges since period start).
module tb_clk_div_bank;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int D0 = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_ch;
  logic [W-1:0] cfg_div;
  logic         cfg_mode;
  logic [N-1:0] clk_out;
  logic [N-1:0] tick;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_bank #(.N_CH(N), .CNT_W(W), .DEF_DIV(D0), .DEF_MODE(1'b0)) dut (
    .clk(clk), .resetn(resetn), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  // model: divisor, mode, staged update and running edges since the period started
  int unsigned m_div  [N];
  bit          m_mode [N];
  bit          m_pend [N];
  int unsigned m_sdiv [N];
  bit          m_smode[N];
  longint      m_n    [N];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready(input logic [1:0] ch);
    if (int'(ch) >= N) return 1'b1;
    return !m_pend[ch];
  endfunction

  function automatic bit exp_clk(input int i);
    if (m_mode[i] || m_div[i] == 0) return 1'b0;
    return ((m_n[i] / m_div[i]) % 2) == 1;
  endfunction

  function automatic bit exp_tick(input int i);
    if (!m_mode[i] || m_div[i] == 0) return 1'b0;
    return (m_n[i] > 0) && ((m_n[i] % m_div[i]) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_div[i] = D0; m_mode[i] = 1'b0; m_pend[i] = 1'b0;
      m_sdiv[i] = 0; m_smode[i] = 1'b0; m_n[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit halted;
    bit boundary;
    acc = cfg_valid && m_ready(cfg_ch);
    for (int i = 0; i < N; i++) begin
      halted   = !en[i] || (m_div[i] == 0);
      boundary = 1'b0;
      if (!halted) boundary = ((m_n[i] + 1) % m_div[i]) == 0;
      if (m_pend[i] && (halted || boundary)) begin
        m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; m_pend[i] = 1'b0; m_n[i] = 0;
      end else if (halted) begin
        m_n[i] = 0;
      end else begin
        m_n[i] = m_n[i] + 1;
      end
    end
    if (acc && int'(cfg_ch) < N) begin
      m_pend[cfg_ch] = 1'b1; m_sdiv[cfg_ch] = cfg_div; m_smode[cfg_ch] = cfg_mode;
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("clk_out%0d", i), 32'(clk_out[i]), 32'(exp_clk(i)));
      check_val($sformatf("tick%0d", i), 32'(tick[i]), 32'(exp_tick(i)));
    end
  endtask

  // called at a falling edge; drives one cycle of inputs and checks the result
  task automatic cycle(input logic [N-1:0] e, input logic v, input logic [1:0] ch,
                       input logic [W-1:0] d, input logic m);
    en = e; cfg_valid = v; cfg_ch = ch; cfg_div = d; cfg_mode = m;
    #1;
    check_val("cfg_ready", 32'(cfg_ready), 32'(m_ready(ch)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input logic [N-1:0] e, input int k);
    for (int j = 0; j < k; j++) cycle(e, 1'b0, 2'd0, 32'd0, 1'b0);
  endtask

  // asynchronous reset mid-cycle: outputs must clear before any clock edge
  task automatic do_reset();
    resetn = 1'b0;
    #2;
    model_reset();
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("rst_clk%0d", i), 32'(clk_out[i]), 32'd0);
      check_val($sformatf("rst_tick%0d", i), 32'(tick[i]), 32'd0);
    end
    check_val("rst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 32'd0; cfg_mode = 1'b0;
    model_reset();
    @(negedge clk);
    check_outs();
    check_val("reset_ready", 32'(cfg_ready), 32'd1);
    resetn = 1'b1;

    // default toggle, div 4, on ch0/ch1
    idle(3'b011, 20);
    // ch1 -> D=3 pulse just after a boundary; repeat to ch1 refused; ch0 accepted
    cycle(3'b011, 1'b1, 2'd1, 32'd3, 1'b1);
    cycle(3'b011, 1'b1, 2'd1, 32'd9, 1'b0);
    cycle(3'b011, 1'b1, 2'd0, 32'd4, 1'b0);
    idle(3'b011, 20);
    // en[0] dropped mid-count, then restored
    idle(3'b011, 2);
    idle(3'b010, 2);
    idle(3'b011, 15);
    // ch0 halted by D=0, then D=1 pulse while halted
    cycle(3'b011, 1'b1, 2'd0, 32'd0, 1'b0);
    idle(3'b011, 10);
    cycle(3'b011, 1'b1, 2'd0, 32'd1, 1'b1);
    idle(3'b011, 8);
    // ch2 configured while disabled, out-of-range ch3 discarded
    cycle(3'b011, 1'b1, 2'd2, 32'd2, 1'b0);
    cycle(3'b011, 1'b1, 2'd3, 32'd2, 1'b1);
    idle(3'b111, 12);
    // reset with an update pending on ch1
    cycle(3'b111, 1'b1, 2'd1, 32'd6, 1'b0);
    idle(3'b111, 1);
    do_reset();
    idle(3'b111, 12);

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      logic [N-1:0] e;
      for (int i = 0; i < N; i++) e[i] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle(e, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
              32'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable and divided-clock generator; a parametrised successor to the fixed 1 Hz divider. Each of N_CH channels divides the system clock by a runtime-programmable divisor, in either square-wave (toggle) or single-cycle-tick (pulse) mode. Reconfiguration uses a valid/ready handshake and is applied glitch-free at the channel's period boundary. It feeds shift-register stepping, LED/blink and display-scan logic.

## Interface
- N_CH, 2, number of independent channels (1..8)
- CNT_W, 32, divisor/counter width
- DEF_DIV, 67_500_000, divisor loaded into every channel at reset
- DEF_MODE, 0, mode at reset: 0 = toggle, 1 = pulse
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- en  input  N_CH  per-channel run enable
- cfg_valid  input  1  configuration request
- cfg_ready  output  1  request can be accepted; combinational, = !pending[cfg_ch]
- cfg_ch  input  $clog2(N_CH) (min 1)  target channel
- cfg_div  input  CNT_W  new divisor D
- cfg_mode  input  1  new mode
- clk_out  output  N_CH  divided square wave (toggle mode), else 0
- tick  output  N_CH  one-cycle pulse per period (pulse mode), else 0

## Operation
- Per channel: cnt (CNT_W), div, mode, output flop, pending flag plus staged div/mode.
- Reset (async): cnt=0, div=DEF_DIV, mode=DEF_MODE, pending=0, clk_out=0, tick=0.
- Running (en=1, div≥1): cnt counts 0..div-1; on the edge where cnt==div-1, cnt←0 and the event fires: toggle mode inverts clk_out; pulse mode sets tick=1 for the following cycle only. Otherwise tick←0.
- Toggle period = 2·div cycles, 50% duty. Pulse period = div cycles. div=1 in pulse mode: tick held high continuously.
- div=0: channel halted, cnt held 0, clk_out and tick forced 0.
- en=0: cnt←0, clk_out←0, tick←0 on next edge; state resumes from cnt=0 when en returns.
- Handshake: transfer when cfg_valid && cfg_ready on a rising edge; staged div/mode captured, pending[cfg_ch]←1. cfg_ch ≥ N_CH: request accepted (cfg_ready=1) and discarded.
- Apply: pending update is committed on the event edge (cnt==div-1) or on any edge where the channel is halted (en=0 or div=0). On commit: div, mode updated, cnt←0, pending←0, clk_out←0, tick←0 (event of that edge suppressed). Outputs never glitch mid-period.
- Channels fully independent; simultaneous events on several channels all occur on the same edge.

## Timing
- Counting starts on first rising edge with resetn=1 and en=1 (edge 1).
- Toggle: clk_out rises after edge div, falls after edge 2·div, repeating.
- Pulse: tick high in cycle after edges div, 2·div, 3·div, ...
- Config acceptance to commit: ≤ current div cycles when running; 1 edge when halted. New period measured from commit edge (commit edge = edge 0).
- cfg_ready drops the cycle after acceptance, rises the cycle after commit.
- Reset asserted mid-period: all outputs 0 immediately (async), pending discarded.

## Test plan
- Reset, N_CH=2, ch0 DEF_DIV=4 toggle, en=11 -> clk_out[0] rises after edge 4, falls after edge 8, period 8; no tick.
- Config ch1 D=3 pulse while running -> cfg_ready low until ch1 boundary; then tick[1] high after commit+3, +6, +9; ch0 unaffected.
- Second cfg_valid to ch1 while pending -> cfg_ready=0, no transfer; cfg to ch0 concurrently -> accepted.
- en[0] dropped mid-count at cnt=2 -> clk_out[0]=0 next cycle; re-enable -> first toggle exactly div edges later.
- cfg D=0 -> commits immediately when halted/at boundary, outputs stay 0; then D=1 pulse -> tick constant high.
- resetn pulsed low mid-period with pending update -> outputs 0 asynchronously, div back to DEF_DIV, cfg_ready=1.
